// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared pipeline definitions: NOP encoding, register-index width, the
// SPECIAL funct codes that classify mult/div and mfhi/mflo, the memory
// wait FSM state type and the load-use hazard helper.
package pipeline_ctrl_pkg;

   localparam int          REG_IDX_W  = 5;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

   localparam logic [5:0]  OP_SPECIAL = 6'h00;
   localparam logic [5:0]  FUNCT_MFHI  = 6'h10;
   localparam logic [5:0]  FUNCT_MFLO  = 6'h12;
   localparam logic [5:0]  FUNCT_MULT  = 6'h18;
   localparam logic [5:0]  FUNCT_MULTU = 6'h19;
   localparam logic [5:0]  FUNCT_DIV   = 6'h1A;
   localparam logic [5:0]  FUNCT_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MS_RUN  = 2'd0,
      MS_WAIT = 2'd1,
      MS_ERR  = 2'd2
   } mem_state_e;

   // $zero is never a real producer, so a load into r0 cannot create a hazard.
   function automatic logic load_use_hit(
      input logic                 ex_mem_read,
      input logic [REG_IDX_W-1:0] ex_rt,
      input logic [REG_IDX_W-1:0] id_rs,
      input logic [REG_IDX_W-1:0] id_rt,
      input logic                 id_uses_rt
   );
      return ex_mem_read && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Hazard/handshake bundle between the pipeline datapath and pipeline_ctrl.
//   master : datapath side, drives ID/EX/MEM status, receives enables/flushes
//   slave  : controller side
interface pipeline_ctrl_if;
   import pipeline_ctrl_pkg::*;

   logic [REG_IDX_W-1:0] id_rs;
   logic [REG_IDX_W-1:0] id_rt;
   logic                 id_uses_rt;
   logic                 id_muldiv;
   logic                 id_mfhilo;
   logic [REG_IDX_W-1:0] ex_rt;
   logic                 ex_mem_read;
   logic                 ex_branch_taken;
   logic                 mem_req;
   logic                 mem_ready;

   logic                 pc_en;
   logic                 ifid_en;
   logic                 idex_en;
   logic                 exmem_en;
   logic                 ifid_flush;
   logic                 idex_flush;
   logic                 memwb_flush;
   logic                 md_start;
   logic                 md_busy;
   logic                 mem_err;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_muldiv, id_mfhilo,
             ex_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en,
             ifid_flush, idex_flush, memwb_flush, md_start, md_busy, mem_err
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_muldiv, id_mfhilo,
             ex_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en,
             ifid_flush, idex_flush, memwb_flush, md_start, md_busy, mem_err
   );

endinterface

// File: rtl/pipeline_ctrl_mdcnt.sv
// pipeline_ctrl_mdcnt
// Mult/div busy tracker: down-counter loaded with MULDIV_LAT on start,
// busy while non-zero.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle start strobe issued to the mult/div unit
//   busy       : result not yet valid
module pipeline_ctrl_mdcnt #(
   parameter int MULDIV_LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy
);

   localparam int            CW    = $clog2(MULDIV_LAT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(MULDIV_LAT);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start)
         cnt_d = LAT_C;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Combines memory wait and
// timeout, taken-branch flush, load-use and hi/lo interlocks into per-stage
// enables and flushes, and issues the mult/div start strobe.
//   clk, rst_n : clock, async active-low reset
//   ctl        : pipeline_ctrl_if.slave (ID/EX/MEM status in, controls out)
//
// Memory FSM
//   state   | meaning
//   MS_RUN  | no outstanding memory wait
//   MS_WAIT | MEM access waiting on mem_ready, wait counter running
//   MS_ERR  | wait exceeded MEM_TIMEOUT, pipeline frozen until reset
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MULDIV_LAT  = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   pipeline_ctrl_if.slave  ctl
);

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   mem_state_e state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [7:0] wait_inc;
   logic       mem_waiting;
   logic       mem_stall;
   logic       load_use;
   logic       hilo_stall;
   logic       md_busy;
   logic       md_start;

   assign mem_waiting = ctl.mem_req & ~ctl.mem_ready;
   assign mem_stall   = mem_waiting | (state_q == MS_ERR);
   assign load_use    = load_use_hit(ctl.ex_mem_read, ctl.ex_rt, ctl.id_rs,
                                     ctl.id_rt, ctl.id_uses_rt);
   assign hilo_stall  = (ctl.id_mfhilo | ctl.id_muldiv) & md_busy;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      wait_inc   = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
      unique case (state_q)
         MS_RUN, MS_WAIT: begin
            // The cycle that first sees the wait already counts toward the timeout.
            if (mem_waiting) begin
               wait_cnt_d = wait_inc;
               state_d    = (wait_inc >= TIMEOUT_C) ? MS_ERR : MS_WAIT;
            end else begin
               wait_cnt_d = '0;
               state_d    = MS_RUN;
            end
         end
         MS_ERR: begin
            state_d = MS_ERR;
         end
         default: begin
            state_d    = MS_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MS_RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Outputs are held at their reset values while rst_n is low so the
   // pipeline sees a clean idle control set regardless of ID/EX inputs.
   always_comb begin
      ctl.pc_en       = 1'b1;
      ctl.ifid_en     = 1'b1;
      ctl.idex_en     = 1'b1;
      ctl.exmem_en    = 1'b1;
      ctl.ifid_flush  = 1'b0;
      ctl.idex_flush  = 1'b0;
      ctl.memwb_flush = 1'b0;
      md_start        = 1'b0;
      if (rst_n) begin
         if (mem_stall) begin
            // Branch stays parked in EX; its flush is issued on release.
            ctl.pc_en       = 1'b0;
            ctl.ifid_en     = 1'b0;
            ctl.idex_en     = 1'b0;
            ctl.exmem_en    = 1'b0;
            ctl.memwb_flush = 1'b1;
         end else if (ctl.ex_branch_taken) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
         end else if (load_use | hilo_stall) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
         end else begin
            md_start = ctl.id_muldiv;
         end
      end
   end

   pipeline_ctrl_mdcnt #(
      .MULDIV_LAT (MULDIV_LAT)
   ) u_mdcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_start),
      .busy  (md_busy)
   );

   assign ctl.md_start = md_start;
   assign ctl.md_busy  = md_busy;
   assign ctl.mem_err  = (state_q == MS_ERR);

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
   import pipeline_ctrl_pkg::*;

   localparam int LAT = 4;
   localparam int TMO = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipeline_ctrl_if bus ();

   pipeline_ctrl #(
      .MULDIV_LAT  (LAT),
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctl   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state: cycles of mult/div busy left, consecutive waits, error
   int m_md_rem;
   int m_wait_run;
   bit m_err;
   bit e_md_start;

   localparam logic [9:0] RESET_OUT = 10'b1111_000_0_0_0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [9:0] dut_out();
      return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
              bus.ifid_flush, bus.idex_flush, bus.memwb_flush,
              bus.md_start, bus.md_busy, bus.mem_err};
   endfunction

   // {pc,ifid,idex,exmem, ifid_fl,idex_fl,memwb_fl, md_start, md_busy, mem_err}
   function automatic logic [9:0] model_out();
      bit waiting = bus.mem_req && !bus.mem_ready;
      bit busy    = (m_md_rem > 0);
      bit lu      = bus.ex_mem_read && (bus.ex_rt != 0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
      bit hl      = (bus.id_mfhilo || bus.id_muldiv) && busy;
      if (waiting || m_err)
         return {4'b0000, 3'b001, 1'b0, busy, m_err};
      else if (bus.ex_branch_taken)
         return {4'b1111, 3'b110, 1'b0, busy, m_err};
      else if (lu || hl)
         return {4'b0011, 3'b010, 1'b0, busy, m_err};
      else
         return {4'b1111, 3'b000, bus.id_muldiv, busy, m_err};
   endfunction

   task automatic m_reset();
      m_md_rem   = 0;
      m_wait_run = 0;
      m_err      = 0;
      e_md_start = 0;
   endtask

   task automatic idle();
      bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
      bus.id_muldiv = 0; bus.id_mfhilo = 0;
      bus.ex_rt = 0; bus.ex_mem_read = 0; bus.ex_branch_taken = 0;
      bus.mem_req = 0; bus.mem_ready = 1;
   endtask

   task automatic sample(input string tag);
      logic [9:0] e;
      @(negedge clk);
      e = model_out();
      e_md_start = e[2];
      chk(tag, 32'(dut_out()), 32'(e));
   endtask

   task automatic advance();
      bit waiting;
      @(posedge clk);
      waiting = bus.mem_req && !bus.mem_ready;
      if (e_md_start) m_md_rem = LAT;
      else if (m_md_rem > 0) m_md_rem--;
      if (!m_err) begin
         if (waiting) begin
            m_wait_run++;
            if (m_wait_run >= TMO) m_err = 1;
         end else begin
            m_wait_run = 0;
         end
      end
      #1;
   endtask

   // Asserts reset with whatever inputs are currently driven, checks outputs
   // drop to reset values at once, then idles and releases.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk(tag, 32'(dut_out()), 32'(RESET_OUT));
      m_reset();
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int stalls;
      int busy_cyc;
      bit done;
      idle();
      m_reset();
      do_reset("reset_vals");

      // load-use on r8: one bubble then free
      bus.ex_mem_read = 1; bus.ex_rt = 8; bus.id_rs = 8;
      sample("lu_model");
      chk("lu_pc_en", 32'(bus.pc_en), 0);
      chk("lu_ifid_en", 32'(bus.ifid_en), 0);
      chk("lu_idex_flush", 32'(bus.idex_flush), 1);
      advance();
      bus.ex_mem_read = 0; bus.ex_rt = 0;
      sample("lu_after");
      chk("lu_after_pc_en", 32'(bus.pc_en), 1);
      advance();
      bus.ex_mem_read = 1; bus.ex_rt = 0; bus.id_rs = 0;
      sample("lu_r0");
      chk("lu_r0_pc_en", 32'(bus.pc_en), 1);
      advance();

      // load-use and taken branch together: branch wins
      bus.ex_rt = 8; bus.id_rs = 8; bus.ex_branch_taken = 1;
      sample("lu_br");
      chk("lu_br_out", 32'(dut_out()), 32'(10'b1111_110_0_0_0));
      advance();
      idle();

      // mult/div followed by mfhi: stalls for exactly LAT cycles
      bus.id_muldiv = 1;
      sample("md_start");
      chk("md_start_hi", 32'(bus.md_start), 1);
      advance();
      bus.id_muldiv = 0; bus.id_mfhilo = 1;
      stalls = 0; busy_cyc = 0; done = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         sample("hilo");
         if (!bus.pc_en) stalls++;
         if (bus.md_busy) busy_cyc++;
         done = bus.pc_en;
         advance();
      end
      chk("hilo_stalls", 32'(stalls), 32'(LAT));
      chk("md_busy_cycles", 32'(busy_cyc), 32'(LAT));
      idle();

      // memory wait with parked branch: frozen 3 cycles, flush on release
      bus.ex_branch_taken = 1; bus.mem_req = 1; bus.mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         sample("mw_model");
         chk("mw_frozen", 32'(dut_out()), 32'(10'b0000_001_0_0_0));
         advance();
      end
      bus.mem_ready = 1;
      sample("mw_release");
      chk("mw_release_out", 32'(dut_out()), 32'(10'b1111_110_0_0_0));
      advance();
      idle();

      // timeout: error after TMO consecutive wait cycles, sticky
      bus.mem_req = 1; bus.mem_ready = 0;
      for (int i = 0; i < TMO + 2; i++) begin
         sample("tmo_model");
         chk("tmo_err", 32'(bus.mem_err), (i >= TMO) ? 32'd1 : 32'd0);
         advance();
      end
      bus.mem_ready = 1;
      sample("tmo_sticky");
      chk("tmo_sticky_pc_en", 32'(bus.pc_en), 0);
      chk("tmo_sticky_err", 32'(bus.mem_err), 1);
      advance();
      do_reset("tmo_reset");

      // reset in the middle of a mult/div with active hazards on the inputs
      bus.id_muldiv = 1;
      sample("rmd_start");
      advance();
      bus.id_muldiv = 0; bus.id_mfhilo = 1;
      for (int i = 0; i < 2; i++) begin
         sample("rmd_busy");
         chk("rmd_busy_hi", 32'(bus.md_busy), 1);
         advance();
      end
      bus.ex_mem_read = 1; bus.ex_rt = 3; bus.id_rs = 3; bus.id_muldiv = 1;
      do_reset("rmd_reset");

      // randomized traffic against the model
      for (int chunk = 0; chunk < 10; chunk++) begin
         for (int c = 0; c < 250; c++) begin
            bus.id_rs           = 5'($urandom_range(0, 3));
            bus.id_rt           = 5'($urandom_range(0, 3));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.id_muldiv       = ($urandom_range(0, 5) == 0);
            bus.id_mfhilo       = ($urandom_range(0, 4) == 0);
            bus.ex_rt           = 5'($urandom_range(0, 3));
            bus.ex_mem_read     = ($urandom_range(0, 2) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
            bus.mem_req         = ($urandom_range(0, 2) == 0);
            bus.mem_ready       = ($urandom_range(0, 3) != 0);
            sample("rnd");
            advance();
         end
         do_reset("rnd_reset");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
